ahb_line_fetch: RTL and testbench

- Downstream refill engine for the I-cache.
- Accepts a line-refill request on the cache's main-memory interface (mem_req/mem_addr).
- Performs one AHB-Lite INCR4 read burst of 32-bit words, assembles the 128-bit line and returns it with mem_ready.
- Sole AHB master of the instruction side; sits between the cache and the AHB interconnect.

---
 rtl/ahb_pkg.sv | 23 ++
 rtl/ahb_line_fetch.sv | 162 ++++++++++++++++
 tb/tb_ahb_line_fetch.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// AHB-Lite encodings and refill FSM states shared by the I-side line fetcher.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [3:0] HPROT_INSN    = 4'b0010;

    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    localparam int WORD_W     = 32;
    localparam int LINE_W_DEF = 128;
    localparam int LINE_BEATS = LINE_W_DEF / WORD_W;

    typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE, ERR} fetch_state_t;

endpackage

// File: rtl/ahb_line_fetch.sv
// I-cache refill engine: one AHB-Lite INCR4 word burst per line miss, the
// beats assembled into a line handed back with a four-phase req/ready handshake.
module ahb_line_fetch
    import ahb_pkg::*;
#(
    parameter int CACHE_LINE = LINE_BEATS * WORD_W,
    parameter int ADDR_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_req,
    input  logic [ADDR_W-1:0]     mem_addr,
    output logic [CACHE_LINE-1:0] mem_data_in,
    output logic                  mem_ready,
    output logic                  fetch_err,
    output logic [ADDR_W-1:0]     HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    input  logic [WORD_W-1:0]     HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    localparam int               BEATS     = CACHE_LINE / WORD_W;
    localparam int               CNT_W     = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    fetch_state_t          state, state_nxt;
    logic [CNT_W-1:0]      acnt, acnt_nxt;
    logic [CNT_W-1:0]      dcnt, dcnt_nxt;
    logic                  dphase, dphase_nxt;
    logic [ADDR_W-1:0]     haddr_nxt;
    logic [1:0]            htrans_nxt;
    logic [2:0]            hburst_nxt;
    logic                  ready_nxt, err_nxt;
    logic [CACHE_LINE-1:0] line_nxt;

    // Read-only word fetches of instruction data; these never change.
    assign HWRITE = 1'b0;
    assign HSIZE  = HSIZE_WORD;
    assign HPROT  = HPROT_INSN;

    // State and every bus/cache-facing output are registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            acnt        <= '0;
            dcnt        <= '0;
            dphase      <= 1'b0;
            HADDR       <= '0;
            HTRANS      <= HTRANS_IDLE;
            HBURST      <= HBURST_SINGLE;
            mem_ready   <= 1'b0;
            fetch_err   <= 1'b0;
            mem_data_in <= '0;
        end else begin
            state       <= state_nxt;
            acnt        <= acnt_nxt;
            dcnt        <= dcnt_nxt;
            dphase      <= dphase_nxt;
            HADDR       <= haddr_nxt;
            HTRANS      <= htrans_nxt;
            HBURST      <= hburst_nxt;
            mem_ready   <= ready_nxt;
            fetch_err   <= err_nxt;
            mem_data_in <= line_nxt;
        end
    end

    // Next-state and next-output logic; address and data phases overlap, so
    // acnt tracks accepted addresses and dcnt tracks completed data beats.
    always_comb begin
        state_nxt  = state;
        acnt_nxt   = acnt;
        dcnt_nxt   = dcnt;
        dphase_nxt = dphase;
        haddr_nxt  = HADDR;
        htrans_nxt = HTRANS;
        hburst_nxt = HBURST;
        ready_nxt  = mem_ready;
        err_nxt    = fetch_err;
        line_nxt   = mem_data_in;

        case (state)
            IDLE: begin
                if (mem_req) begin
                    state_nxt  = ADDR;
                    haddr_nxt  = {mem_addr[ADDR_W-1:4], 4'b0000};
                    htrans_nxt = HTRANS_NONSEQ;
                    hburst_nxt = HBURST_INCR4;
                    acnt_nxt   = '0;
                    dcnt_nxt   = '0;
                    dphase_nxt = 1'b0;
                end
            end

            ADDR, DATA: begin
                if (dphase && HRESP == HRESP_ERROR) begin
                    // Cancel the rest of the burst right away; the line is dropped.
                    htrans_nxt = HTRANS_IDLE;
                    hburst_nxt = HBURST_SINGLE;
                    dphase_nxt = 1'b0;
                    if (HREADY) begin
                        state_nxt = DONE;
                        ready_nxt = 1'b1;
                        err_nxt   = 1'b1;
                        line_nxt  = '0;
                    end else begin
                        state_nxt = ERR;
                    end
                end else if (HREADY) begin
                    dphase_nxt = (HTRANS != HTRANS_IDLE);
                    if (HTRANS != HTRANS_IDLE) begin
                        if (acnt == LAST_BEAT) begin
                            htrans_nxt = HTRANS_IDLE;
                            hburst_nxt = HBURST_SINGLE;
                            state_nxt  = DATA;
                        end else begin
                            acnt_nxt   = acnt + 1'b1;
                            haddr_nxt  = HADDR + ADDR_W'(4);
                            htrans_nxt = HTRANS_SEQ;
                        end
                    end
                    if (dphase) begin
                        // Beat k lands in word k, matching the cache's offset slice.
                        for (int i = 0; i < BEATS; i++) begin
                            if (dcnt == CNT_W'(i)) line_nxt[i*WORD_W +: WORD_W] = HRDATA;
                        end
                        dcnt_nxt = dcnt + 1'b1;
                        if (dcnt == LAST_BEAT) begin
                            state_nxt = DONE;
                            ready_nxt = 1'b1;
                        end
                    end
                end
            end

            ERR: begin
                if (HREADY) begin
                    state_nxt = DONE;
                    ready_nxt = 1'b1;
                    err_nxt   = 1'b1;
                    line_nxt  = '0;
                end
            end

            DONE: begin
                if (!mem_req) begin
                    state_nxt = IDLE;
                    ready_nxt = 1'b0;
                    err_nxt   = 1'b0;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ahb_line_fetch.sv
// Bench for ahb_line_fetch: a behavioural AHB slave with per-beat wait and
// error injection, plus expectations derived from AHB pipeline rules.
module tb_ahb_line_fetch;
    import ahb_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic [127:0] mem_data_in;
    logic         mem_ready;
    logic         fetch_err;
    logic [31:0]  HADDR;
    logic [1:0]   HTRANS;
    logic         HWRITE;
    logic [2:0]   HSIZE;
    logic [2:0]   HBURST;
    logic [3:0]   HPROT;
    logic [31:0]  HRDATA;
    logic         HREADY;
    logic         HRESP;

    always #5 clk = ~clk;

    ahb_line_fetch dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_ready(mem_ready), .fetch_err(fetch_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HRDATA(HRDATA), .HREADY(HREADY),
        .HRESP(HRESP)
    );

    int vectors = 0;
    int miscompares = 0;

    // scenario knobs
    logic [31:0] words [4];
    int          waits [4];
    int          err_beat;
    int          drop_at;

    // observations of the last burst
    int          obs_lat, obs_first, obs_hburst_bad;
    int          obs_hold [4];
    bit          obs_err_idle;
    logic [31:0] obs_addr [$];
    logic [1:0]  obs_trans [$];

    // Every slave wait cycle delays completion by one; an error costs two
    // cycles in its data phase and completes the line right after.
    function automatic int exp_lat();
        int s = 0;
        int n = (err_beat < 0) ? 4 : err_beat;
        for (int k = 0; k < n; k++) s += waits[k];
        return (err_beat < 0) ? 6 + s : err_beat + 4 + s;
    endfunction

    function automatic logic [127:0] exp_line();
        return {words[3], words[2], words[1], words[0]};
    endfunction

    task automatic plain_scenario();
        for (int k = 0; k < 4; k++) begin
            waits[k] = 0;
            words[k] = $urandom;
        end
        err_beat = -1;
        drop_at  = -1;
    endtask

    // Raise a request at the current cycle (cycle 0) and play AHB slave until
    // mem_ready appears; mem_addr is scrambled after acceptance.
    task automatic run_burst(input logic [31:0] addr);
        logic [31:0] base;
        bit          dp_valid;
        logic [31:0] dp_addr;
        int          wleft, err_phase, k;
        logic [1:0]  t_s;
        logic [31:0] a_s;
        base = {addr[31:4], 4'b0000};
        dp_valid = 1'b0; dp_addr = '0; wleft = 0; err_phase = 0;
        obs_lat = -1; obs_first = -1; obs_hburst_bad = 0; obs_err_idle = 1'b0;
        obs_addr.delete(); obs_trans.delete();
        for (int i = 0; i < 4; i++) obs_hold[i] = 0;
        mem_req = 1'b1; mem_addr = addr;
        for (int cyc = 0; cyc < 60; cyc++) begin
            t_s = HTRANS; a_s = HADDR;
            if (mem_ready === 1'b1) begin obs_lat = cyc; break; end
            if (t_s !== 2'b00) begin
                if (obs_first < 0) obs_first = cyc;
                k = int'((a_s - base) >> 2);
                if (k >= 0 && k < 4) obs_hold[k]++;
                if (HBURST !== 3'b011) obs_hburst_bad++;
            end else if (HBURST !== 3'b000) obs_hburst_bad++;
            if (err_phase == 1) obs_err_idle = (t_s === 2'b00);
            if (cyc >= 1) mem_addr = $urandom;
            if (cyc == drop_at) mem_req = 1'b0;
            HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
            if (dp_valid) begin
                if (int'(dp_addr[3:2]) == err_beat) begin
                    HRESP  = 1'b1;
                    HREADY = (err_phase != 0);
                    err_phase++;
                end else if (wleft > 0) begin
                    HREADY = 1'b0;
                    wleft--;
                end else begin
                    HRDATA = words[dp_addr[3:2]];
                end
            end
            @(posedge clk); #1;
            if (HREADY) begin
                dp_valid = (t_s !== 2'b00);
                dp_addr  = a_s;
                if (dp_valid) begin
                    obs_addr.push_back(a_s);
                    obs_trans.push_back(t_s);
                    wleft = waits[a_s[3:2]];
                end
            end
        end
        HREADY = 1'b1; HRESP = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; mem_req = 1'b0; mem_addr = '0;
        HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (HTRANS !== 2'b00) begin miscompares++; $display("FAIL reset_htrans got %b exp 00", HTRANS); end
        vectors++; if (HADDR !== 32'h0) begin miscompares++; $display("FAIL reset_haddr got %h exp 0", HADDR); end
        vectors++; if (HBURST !== 3'b000) begin miscompares++; $display("FAIL reset_hburst got %b exp 000", HBURST); end
        vectors++; if (mem_ready !== 1'b0 || fetch_err !== 1'b0) begin miscompares++; $display("FAIL reset_flags got ready=%b err=%b exp 0/0", mem_ready, fetch_err); end
        vectors++; if (mem_data_in !== 128'h0) begin miscompares++; $display("FAIL reset_line got %h exp 0", mem_data_in); end
        vectors++; if (HWRITE !== 1'b0 || HSIZE !== 3'b010 || HPROT !== 4'b0010) begin miscompares++; $display("FAIL const_ctrl got w=%b s=%b p=%b exp 0/010/0010", HWRITE, HSIZE, HPROT); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_wait();
        plain_scenario();
        for (int k = 0; k < 4; k++) words[k] = 32'hA0 + k;
        run_burst(32'h0000_1234);
        vectors++; if (obs_lat != 6) begin miscompares++; $display("FAIL zw_latency got %0d exp 6", obs_lat); end
        vectors++; if (obs_addr.size() != 4) begin miscompares++; $display("FAIL zw_beats got %0d exp 4", obs_addr.size()); end
        for (int k = 0; k < 4 && k < obs_addr.size(); k++) begin
            vectors++;
            if (obs_addr[k] !== 32'h1230 + 32'(4 * k) || obs_trans[k] !== ((k == 0) ? 2'b10 : 2'b11)) begin
                miscompares++;
                $display("FAIL zw_addr%0d got %h/%b exp %h/%b", k, obs_addr[k], obs_trans[k], 32'h1230 + 32'(4 * k), (k == 0) ? 2'b10 : 2'b11);
            end
        end
        vectors++; if (obs_hburst_bad != 0) begin miscompares++; $display("FAIL zw_hburst got %0d bad cycles exp 0", obs_hburst_bad); end
        vectors++; if (mem_data_in !== 128'h000000A3_000000A2_000000A1_000000A0) begin miscompares++; $display("FAIL zw_line got %h", mem_data_in); end
        vectors++; if (fetch_err !== 1'b0) begin miscompares++; $display("FAIL zw_err got %b exp 0", fetch_err); end
        mem_req = 1'b0; @(posedge clk); #1;
        vectors++; if (mem_ready !== 1'b0) begin miscompares++; $display("FAIL zw_release got %b exp 0", mem_ready); end
    endtask

    task automatic test_wait_states();
        plain_scenario();
        for (int k = 0; k < 4; k++) words[k] = 32'hA0 + k;
        waits[1] = 2;
        run_burst(32'h0000_1234);
        vectors++; if (obs_lat != 8) begin miscompares++; $display("FAIL ws_latency got %0d exp 8", obs_lat); end
        vectors++; if (obs_hold[2] != 3) begin miscompares++; $display("FAIL ws_hold_1238 got %0d exp 3", obs_hold[2]); end
        vectors++; if (mem_data_in !== exp_line()) begin miscompares++; $display("FAIL ws_line got %h exp %h", mem_data_in, exp_line()); end
        mem_req = 1'b0; @(posedge clk); #1;
        vectors++; if (mem_ready !== 1'b0) begin miscompares++; $display("FAIL ws_release got %b exp 0", mem_ready); end
    endtask

    task automatic test_error();
        plain_scenario();
        err_beat = 1;
        run_burst(32'h0000_1234);
        vectors++; if (obs_lat != 5) begin miscompares++; $display("FAIL err_latency got %0d exp 5", obs_lat); end
        vectors++; if (obs_err_idle !== 1'b1) begin miscompares++; $display("FAIL err_cancel got %b exp 1", obs_err_idle); end
        vectors++; if (obs_addr.size() != 2) begin miscompares++; $display("FAIL err_addr_phases got %0d exp 2", obs_addr.size()); end
        vectors++; if (fetch_err !== 1'b1 || mem_data_in !== 128'h0) begin miscompares++; $display("FAIL err_result got err=%b line=%h exp 1/0", fetch_err, mem_data_in); end
        mem_req = 1'b0; @(posedge clk); #1;
        vectors++; if (mem_ready !== 1'b0 || fetch_err !== 1'b0) begin miscompares++; $display("FAIL err_release got %b/%b exp 0/0", mem_ready, fetch_err); end
    endtask

    task automatic test_handshake();
        logic [127:0] line;
        plain_scenario();
        run_burst(32'h0000_5678);
        line = exp_line();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (mem_ready !== 1'b1 || mem_data_in !== line) begin
                miscompares++;
                $display("FAIL hs_hold%0d got %b/%h exp 1/%h", i, mem_ready, mem_data_in, line);
            end
        end
        mem_req = 1'b0; @(posedge clk); #1;
        vectors++; if (mem_ready !== 1'b0) begin miscompares++; $display("FAIL hs_drop got %b exp 0", mem_ready); end
        plain_scenario();
        run_burst(32'h0000_2000);
        vectors++; if (obs_first != 1 || obs_trans.size() == 0 || obs_trans[0] !== 2'b10 || obs_addr[0] !== 32'h2000) begin
            miscompares++; $display("FAIL hs_restart got first_cyc=%0d nphases=%0d exp 1 NONSEQ 2000", obs_first, obs_trans.size());
        end
        vectors++; if (mem_data_in !== exp_line()) begin miscompares++; $display("FAIL hs_line got %h exp %h", mem_data_in, exp_line()); end
        mem_req = 1'b0; @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_burst();
        mem_req = 1'b1; mem_addr = 32'h0000_3004;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (HTRANS !== 2'b11) begin miscompares++; $display("FAIL rm_pre got %b exp 11", HTRANS); end
        #2 rst = 1'b0;
        #1;
        vectors++; if (HTRANS !== 2'b00 || HADDR !== 32'h0) begin miscompares++; $display("FAIL rm_bus got %b/%h exp 00/0", HTRANS, HADDR); end
        vectors++; if (mem_ready !== 1'b0 || mem_data_in !== 128'h0) begin miscompares++; $display("FAIL rm_cache got %b/%h exp 0/0", mem_ready, mem_data_in); end
        @(posedge clk); #1;
        rst = 1'b1;
        plain_scenario();
        run_burst(32'h0000_3004);
        vectors++; if (obs_first != 1 || obs_addr.size() != 4 || obs_addr[0] !== 32'h3000) begin
            miscompares++; $display("FAIL rm_fresh got first_cyc=%0d nphases=%0d exp 1/4 from 3000", obs_first, obs_addr.size());
        end
        vectors++; if (mem_data_in !== exp_line() || obs_lat != 6) begin miscompares++; $display("FAIL rm_line got %h lat %0d exp %h lat 6", mem_data_in, obs_lat, exp_line()); end
        mem_req = 1'b0; @(posedge clk); #1;
    endtask

    task automatic test_top_addr();
        plain_scenario();
        run_burst(32'hFFFF_FFFC);
        vectors++; if (obs_addr.size() != 4) begin miscompares++; $display("FAIL top_beats got %0d exp 4", obs_addr.size()); end
        for (int k = 0; k < 4 && k < obs_addr.size(); k++) begin
            vectors++;
            if (obs_addr[k] !== 32'hFFFF_FFF0 + 32'(4 * k)) begin miscompares++; $display("FAIL top_addr%0d got %h exp %h", k, obs_addr[k], 32'hFFFF_FFF0 + 32'(4 * k)); end
        end
        vectors++; if (mem_data_in !== exp_line()) begin miscompares++; $display("FAIL top_line got %h exp %h", mem_data_in, exp_line()); end
        mem_req = 1'b0; @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [31:0] addr, base;
        int          nexp;
        for (int it = 0; it < 20; it++) begin
            plain_scenario();
            for (int k = 0; k < 4; k++) waits[k] = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
            err_beat = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : -1;
            drop_at  = ($urandom_range(0, 2) == 0) ? $urandom_range(2, 5) : -1;
            addr = $urandom;
            base = {addr[31:4], 4'b0000};
            run_burst(addr);
            nexp = (err_beat < 0) ? 4 : err_beat + 1;
            vectors++; if (obs_lat != exp_lat()) begin miscompares++; $display("FAIL rnd%0d_latency got %0d exp %0d", it, obs_lat, exp_lat()); end
            vectors++; if (obs_addr.size() != nexp) begin miscompares++; $display("FAIL rnd%0d_phases got %0d exp %0d", it, obs_addr.size(), nexp); end
            for (int k = 0; k < nexp && k < obs_addr.size(); k++) begin
                vectors++;
                if (obs_addr[k] !== base + 32'(4 * k) || obs_trans[k] !== ((k == 0) ? 2'b10 : 2'b11)) begin
                    miscompares++;
                    $display("FAIL rnd%0d_addr%0d got %h/%b exp %h", it, k, obs_addr[k], obs_trans[k], base + 32'(4 * k));
                end
            end
            vectors++; if (obs_hburst_bad != 0) begin miscompares++; $display("FAIL rnd%0d_hburst got %0d bad cycles exp 0", it, obs_hburst_bad); end
            if (err_beat < 0) begin
                vectors++; if (mem_data_in !== exp_line() || fetch_err !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_line got %h err %b exp %h", it, mem_data_in, fetch_err, exp_line()); end
                for (int k = 1; k < 4; k++) begin
                    vectors++;
                    if (obs_hold[k] != 1 + waits[k-1]) begin miscompares++; $display("FAIL rnd%0d_hold%0d got %0d exp %0d", it, k, obs_hold[k], 1 + waits[k-1]); end
                end
            end else begin
                vectors++; if (fetch_err !== 1'b1 || mem_data_in !== 128'h0 || obs_err_idle !== 1'b1) begin miscompares++; $display("FAIL rnd%0d_err got %b/%h/%b exp 1/0/1", it, fetch_err, mem_data_in, obs_err_idle); end
            end
            mem_req = 1'b0; @(posedge clk); #1;
            vectors++; if (mem_ready !== 1'b0 || fetch_err !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_release got %b/%b exp 0/0", it, mem_ready, fetch_err); end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_error();
        test_handshake();
        test_reset_mid_burst();
        test_top_addr();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d vectors", vectors);
        $fatal(1, "timeout");
    end

endmodule
